// File: rtl/ysyx_23060136_exu_div_ctrl.sv
// Issue-side controller for the iterative EXU divider: takes one RV64M divide op,
// short-circuits div-by-zero / signed overflow, and formats the result for the pipeline.
module ysyx_23060136_exu_div_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_rem,
    input  logic             in_signed,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_valid,
    input  logic             div_ready,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    output logic             div_divw,
    output logic             div_signed,
    input  logic             div_out_valid,
    input  logic [XLEN-1:0]  div_quotient,
    input  logic [XLEN-1:0]  div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    dividend_q, dividend_d;
    logic [XLEN-1:0]    divisor_q, divisor_d;
    logic               rem_q, rem_d;
    logic               signed_q, signed_d;
    logic               word_q, word_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]    result_q, result_d;

    logic               divisor_zero;
    logic               overflow;
    logic [XLEN-1:0]    special_raw;

    // W ops always sign-extend bit 31, even for unsigned and bypassed results
    function automatic logic [XLEN-1:0] fmt_w(input logic word, input logic [XLEN-1:0] r);
        return word ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

    always_comb begin
        divisor_zero = in_word ? (in_rs2[31:0] == 32'h0) : (in_rs2 == '0);
        overflow     = in_signed &
                       (in_word ? ((in_rs1[31:0] == 32'h8000_0000) && (in_rs2[31:0] == 32'hFFFF_FFFF))
                                : ((in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1)));
        if (divisor_zero) begin
            special_raw = in_rem ? in_rs1 : '1;
        end else begin
            special_raw = in_rem ? '0 : in_rs1;
        end
    end

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        signed_d   = signed_q;
        word_d     = word_q;
        tag_d      = tag_q;
        result_d   = result_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    dividend_d = in_rs1;
                    divisor_d  = in_rs2;
                    rem_d      = in_rem;
                    signed_d   = in_signed;
                    word_d     = in_word;
                    tag_d      = in_tag;
                    if (divisor_zero || overflow) begin
                        result_d = fmt_w(in_word, special_raw);
                        state_d  = DONE;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (div_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (div_out_valid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        result_d = fmt_w(word_q, rem_q ? div_remainder : div_quotient);
                        state_d  = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            // The divider cannot be aborted, so its late result is swallowed here
            DRAIN: begin
                if (div_out_valid) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= 1'b0;
            signed_q   <= 1'b0;
            word_q     <= 1'b0;
            tag_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            signed_q   <= signed_d;
            word_q     <= word_d;
            tag_q      <= tag_d;
            result_q   <= result_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign div_valid    = (state_q == ISSUE);
    assign out_valid    = (state_q == DONE);
    assign out_result   = result_q;
    assign out_tag      = tag_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign div_divw     = word_q;
    assign div_signed   = signed_q;

endmodule

// File: tb/tb_ysyx_23060136_exu_div_ctrl.sv
// Directed bench for the divider issue controller; the bench plays the divider by hand.
module tb_ysyx_23060136_exu_div_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_rem, in_signed, in_word;
    logic        in_ready;
    logic [63:0] in_rs1, in_rs2;
    logic [4:0]  in_tag;
    logic        div_valid, div_ready, div_divw, div_signed;
    logic [63:0] div_dividend, div_divisor;
    logic        div_out_valid;
    logic [63:0] div_quotient, div_remainder;
    logic        out_valid, out_ready, busy;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int div_valid_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (div_valid) div_valid_cnt <= div_valid_cnt + 1;

    ysyx_23060136_exu_div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rem(in_rem), .in_signed(in_signed),
        .in_word(in_word), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .div_valid(div_valid), .div_ready(div_ready), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_divw(div_divw), .div_signed(div_signed),
        .div_out_valid(div_out_valid), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic rem, input logic sgn, input logic word,
                          input logic [63:0] rs1, input logic [63:0] rs2, input logic [4:0] tag);
        in_valid = 1'b1; in_rem = rem; in_signed = sgn; in_word = word;
        in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
        tick();
        in_valid = 1'b0;
    endtask

    // Full op: accept, optionally play the divider, check result, then out handshake
    task automatic run_op(input string name, input logic rem, input logic sgn, input logic word,
                          input logic [63:0] rs1, input logic [63:0] rs2, input logic [4:0] tag,
                          input logic bypass, input logic [63:0] q, input logic [63:0] r,
                          input logic [63:0] exp_res);
        int start_cnt;
        start_cnt = div_valid_cnt;
        accept(rem, sgn, word, rs1, rs2, tag);
        if (!bypass) begin
            total_cnt++; if (div_valid !== 1'b1) $display("FAIL %s div_valid got %b want 1", name, div_valid); else pass_cnt++;
            total_cnt++; if (div_dividend !== rs1 || div_divisor !== rs2) $display("FAIL %s operands got %h/%h want %h/%h", name, div_dividend, div_divisor, rs1, rs2); else pass_cnt++;
            tick();
            total_cnt++; if (div_valid !== 1'b0 || busy !== 1'b1) $display("FAIL %s wait div_valid/busy got %b/%b want 0/1", name, div_valid, busy); else pass_cnt++;
            tick();
            div_out_valid = 1'b1; div_quotient = q; div_remainder = r;
            tick();
            div_out_valid = 1'b0; div_quotient = 64'hDEAD_BEEF_DEAD_BEEF; div_remainder = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL %s out_valid got %b want 1", name, out_valid); else pass_cnt++;
        total_cnt++; if (out_result !== exp_res) $display("FAIL %s result got %h want %h", name, out_result, exp_res); else pass_cnt++;
        total_cnt++; if (out_tag !== tag) $display("FAIL %s tag got %h want %h", name, out_tag, tag); else pass_cnt++;
        total_cnt++; if ((div_valid_cnt - start_cnt) !== (bypass ? 0 : 1)) $display("FAIL %s div_valid cycles got %0d want %0d", name, div_valid_cnt - start_cnt, bypass ? 0 : 1); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL %s after out handshake out_valid/in_ready got %b/%b want 0/1", name, out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset in_ready/busy got %b/%b want 1/0", in_ready, busy); else pass_cnt++;
        total_cnt++; if (div_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset div_valid/out_valid got %b/%b want 0/0", div_valid, out_valid); else pass_cnt++;
        total_cnt++; if (out_result !== 64'h0 || out_tag !== 5'h0) $display("FAIL reset result/tag got %h/%h want 0/0", out_result, out_tag); else pass_cnt++;
        total_cnt++; if (div_dividend !== 64'h0 || div_divisor !== 64'h0) $display("FAIL reset operands got %h/%h want 0/0", div_dividend, div_divisor); else pass_cnt++;
    endtask

    task automatic test_normal();
        run_op("div_100_m7", 1'b0, 1'b1, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd3, 1'b0,
               64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op("rem_100_m7", 1'b1, 1'b1, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd4, 1'b0,
               64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 64'd2);
        run_op("divuw_sext", 1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd5, 1'b0,
               64'h0000_0000_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic test_special();
        run_op("divu_zero", 1'b0, 1'b0, 1'b0, 64'd5, 64'd0, 5'd6, 1'b1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_zero", 1'b1, 1'b0, 1'b0, 64'd5, 64'd0, 5'd7, 1'b1, 64'd0, 64'd0, 64'd5);
        run_op("divw_ovf", 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b1,
               64'd0, 64'd0, 64'hFFFF_FFFF_8000_0000);
        run_op("remw_ovf", 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b1,
               64'd0, 64'd0, 64'h0);
        run_op("div64_ovf", 1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 1'b1,
               64'd0, 64'd0, 64'h8000_0000_0000_0000);
        run_op("remw_zero_lo", 1'b1, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000, 5'd11, 1'b1,
               64'd0, 64'd0, 64'hFFFF_FFFF_9ABC_DEF0);
    endtask

    task automatic test_flush_drain();
        accept(1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 5'd12);
        tick();
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL drain%0d in_ready/out_valid/busy got %b/%b/%b want 0/0/1", i, in_ready, out_valid, busy); else pass_cnt++;
            tick();
        end
        div_out_valid = 1'b1; div_quotient = 64'd14; div_remainder = 64'd2;
        tick();
        div_out_valid = 1'b0;
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL drain_exit in_ready/out_valid got %b/%b want 1/0", in_ready, out_valid); else pass_cnt++;
        run_op("div_42_6", 1'b0, 1'b1, 1'b0, 64'd42, 64'd6, 5'd13, 1'b0, 64'd7, 64'd0, 64'd7);
    endtask

    task automatic test_flush_issue();
        div_ready = 1'b0;
        accept(1'b0, 1'b0, 1'b0, 64'd9, 64'd3, 5'd14);
        tick();
        total_cnt++; if (div_valid !== 1'b1) $display("FAIL issue_hold div_valid got %b want 1", div_valid); else pass_cnt++;
        flush = 1'b1; div_ready = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++; if (div_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL issue_flush div_valid/in_ready got %b/%b want 0/1", div_valid, in_ready); else pass_cnt++;
        flush = 1'b1;
        accept(1'b0, 1'b0, 1'b0, 64'd9, 64'd3, 5'd14);
        flush = 1'b0;
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL idle_flush in_ready/busy got %b/%b want 1/0", in_ready, busy); else pass_cnt++;
    endtask

    task automatic test_hold_and_rst();
        accept(1'b0, 1'b1, 1'b0, 64'd50, 64'd5, 5'd21);
        tick(); tick();
        div_out_valid = 1'b1; div_quotient = 64'd10; div_remainder = 64'd0;
        tick();
        div_out_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (out_valid !== 1'b1 || out_result !== 64'd10 || out_tag !== 5'd21 || in_ready !== 1'b0)
                $display("FAIL hold%0d valid/result/tag/in_ready got %b/%h/%h/%b want 1/a/15/0", i, out_valid, out_result, out_tag, in_ready);
            else pass_cnt++;
            tick();
        end
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL done_flush out_valid/in_ready got %b/%b want 0/1", out_valid, in_ready); else pass_cnt++;
        accept(1'b0, 1'b1, 1'b0, 64'd77, 64'd7, 5'd22);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0 || div_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_wait ctrl got %b%b%b%b want 1000", in_ready, busy, div_valid, out_valid); else pass_cnt++;
        total_cnt++; if (out_result !== 64'h0 || out_tag !== 5'h0 || div_dividend !== 64'h0 || div_divisor !== 64'h0) $display("FAIL rst_wait data got %h/%h/%h/%h want 0", out_result, out_tag, div_dividend, div_divisor); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rem = 1'b0; in_signed = 1'b0; in_word = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_tag = '0; div_ready = 1'b1; div_out_valid = 1'b0;
        div_quotient = '0; div_remainder = '0; out_ready = 1'b0;
        test_reset();
        test_normal();
        test_special();
        test_flush_drain();
        test_flush_issue();
        test_hold_and_rst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
